// File: rtl/return_source_pkg.sv
// Shared definitions for the return_source block: default word width and output FSM encoding.
package return_source_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/return_source_sync_fifo.sv
// Synchronous FIFO: storage array, registered pointers and occupancy count with full/empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/return_source.sv
// Return-path valid/ready transmitter: FIFO-buffered words driven back toward the source side.
// Optional stall counter enabled by defining RETURN_STALL_CNT_EN.
//
// state | meaning
// IDLE  | output register empty, rsp_valid low
// SEND  | output register holds a word, rsp_valid high until accepted
module return_source
  import return_source_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
`ifdef RETURN_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  state_t           state;
  logic             push;
  logic             load;
  logic [WIDTH-1:0] head;

  assign push      = wr_en && !fifo_full;
  assign load      = !fifo_empty && (!rsp_valid || rsp_ready);
  assign rsp_valid = (state == SEND);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (wr_data),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rsp_data <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && fifo_full;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= SEND;
            rsp_data <= head;
          end
        end
        SEND: begin
          if (rsp_ready) begin
            if (load) rsp_data <= head;
            else      state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RETURN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (rsp_valid && !rsp_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_return_source.sv
// Directed self-checking bench for return_source (default build; stall counter checked when RETURN_STALL_CNT_EN is defined).
module tb_return_source;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
`ifdef RETURN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  return_source #(.WIDTH(32), .DEPTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data)
`ifdef RETURN_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] held;
  logic        hold;
  int          pushed;
  int          got;
  int          cyc;
  bit          started;

  initial begin
    // reset state
    step();
    step();
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    rstn = 1'b1;
    step();

    // single word, two-clock latency
    rsp_ready = 1'b1;
    wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    step();
    wr_en = 1'b0;
    check("lat_empty_fall", fifo_empty, 0);
    check("lat_valid_early", rsp_valid, 0);
    step();
    check("lat_valid", rsp_valid, 1);
    check("lat_data", rsp_data, 32'hA5A5_0001);
    check("lat_empty_back", fifo_empty, 1);
    step();
    check("lat_valid_drop", rsp_valid, 0);

    // fill with ready low: 16 in FIFO + 1 in output register
    rsp_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 32'h10 + i;
      step();
      if (i == 15) check("not_full_yet", fifo_full, 0);
    end
    check("full", fifo_full, 1);
    check("hold_data_full", rsp_data, 32'h10);
    wr_data = 32'h99;
    step();
    wr_en = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("full_after_drop", fifo_full, 1);
    step();
    check("ovf_clear", overflow, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", rsp_valid, 1);
      check("drain_data", rsp_data, 32'h10 + i);
      step();
    end
    check("drain_done", rsp_valid, 0);
    check("drain_empty", fifo_empty, 1);

    // stall: data held stable for 5 cycles
    rsp_ready = 1'b0;
    wr_en = 1'b1; wr_data = 32'hC0DE_0005;
    step();
    wr_en = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 32'hC0DE_0005);
      step();
    end
`ifdef RETURN_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`endif
    rsp_ready = 1'b1;
    step();
    check("stall_release", rsp_valid, 0);

    // continuous streaming of 100 words
    got = 0; started = 0; cyc = 0;
    while (got < 100 && cyc < 120) begin
      wr_en = (cyc < 100);
      wr_data = 32'h1000 + cyc;
      step();
      cyc++;
      if (cyc >= 100) wr_en = 1'b0;
      if (started) check("stream_no_bubble", rsp_valid, 1);
      if (rsp_valid) begin
        check("stream_data", rsp_data, 32'h1000 + got);
        check("stream_count_le1", fifo_full, 0);
        got++;
        started = 1;
      end
    end
    wr_en = 1'b0;
    check("stream_total", got, 100);
    step();
    check("stream_idle", rsp_valid, 0);

    // reset while words are buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 32'h500 + i;
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_valid", rsp_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_empty", fifo_empty, 1);
    step();
    rstn = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", rsp_valid, 0);
    end
    wr_en = 1'b1; wr_data = 32'h77;
    step();
    wr_en = 1'b0;
    step();
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 32'h77);
    step();

    // pseudo-random ready against a scoreboard
    pushed = 0; cyc = 0; hold = 0;
    while ((pushed < 1000 || sb.size() != 0 || rsp_valid) && cyc < 20000) begin
      wr_en = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      wr_data = $urandom;
      rsp_ready = (pushed >= 1000) ? 1'b1 : ($urandom_range(0, 1) == 1);
      #1;
      if (hold) begin
        check("rnd_valid_held", rsp_valid, 1);
        check("rnd_data_held", rsp_data, held);
      end
      if (wr_en && !fifo_full) begin
        sb.push_back(wr_data);
        pushed++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rnd_spurious", rsp_valid, 0);
        else check("rnd_data", rsp_data, sb.pop_front());
      end
      hold = rsp_valid && !rsp_ready;
      held = rsp_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    wr_en = 1'b0;
    check("rnd_pushed", pushed, 1000);
    check("rnd_sb_empty", sb.size(), 0);
    check("rnd_end_idle", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
